btb_update_ctrl: RTL and testbench

Sequencer and arbiter for the branch target buffer write port. It accepts resolved-branch updates from `NREQ` branch functional units and buffers each requester's updates in a small FIFO. It grants the single BTB write port round-robin and commits a write only on `ihit`, the BTB's write qualifier. It also runs a full-table invalidation sweep on request, used on context switch or kernel launch.

---
 rtl/btb_update_ctrl_if.sv | 27 ++
 rtl/btb_update_ctrl.sv | 154 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Bundle of the requester, flush-control and BTB write-port signals of btb_update_ctrl.
interface btb_update_ctrl_if #(
  parameter int unsigned NREQ = 2
) ();
  logic                 ihit;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_pc;
  logic [NREQ*32-1:0]   req_target;
  logic                 flush_req;
  logic                 flush_busy;
  logic                 flush_done;
  logic                 btb_wen;
  logic [31:0]          btb_pc;
  logic [31:0]          btb_target;
  logic                 btb_valid;

  modport master (
    output ihit, req_valid, req_pc, req_target, flush_req,
    input  req_ready, flush_busy, flush_done, btb_wen, btb_pc, btb_target, btb_valid
  );

  modport slave (
    input  ihit, req_valid, req_pc, req_target, flush_req,
    output req_ready, flush_busy, flush_done, btb_wen, btb_pc, btb_target, btb_valid
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: per-requester update FIFOs, round-robin grant committed
// on ihit, and a full-table invalidation sweep on flush request.
module btb_update_ctrl #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IDX_SIZE   = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  btb_update_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_SIZE-1:0] IDX_LAST = '1;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [RR_W-1:0]     RR_LAST  = RR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [RR_W-1:0]     r_rr;
  logic [IDX_SIZE-1:0] r_idx;
  logic [CNT_W-1:0]    r_cnt  [NREQ];
  logic [PTR_W-1:0]    r_rptr [NREQ];
  logic [PTR_W-1:0]    r_wptr [NREQ];
  logic [31:0]         r_pc   [NREQ][FIFO_DEPTH];
  logic [31:0]         r_tgt  [NREQ][FIFO_DEPTH];

  logic                w_idle_open;
  logic                w_any;
  logic [RR_W-1:0]     w_win;
  logic [NREQ-1:0]     w_ready;
  logic [NREQ-1:0]     w_push;
  logic [NREQ-1:0]     w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A pending flush request closes the update path for the whole cycle.
  assign w_idle_open = (r_state == IDLE) && !bus.flush_req;

  always_comb begin
    w_ready = '0;
    w_push  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_ready[i] = nRST && w_idle_open && (r_cnt[i] < CNT_FULL);
      w_push[i]  = bus.req_valid[i] && w_ready[i];
    end
  end

  // Winner: first non-empty FIFO scanning upward from the round-robin pointer.
  always_comb begin
    logic [RR_W-1:0] w_cand;
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = (32'(r_rr) + k >= NREQ) ? RR_W'(32'(r_rr) + k - NREQ) : RR_W'(32'(r_rr) + k);
      if (!w_any && (r_cnt[w_cand] != '0)) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_pop[i] = w_idle_open && w_any && bus.ihit && (w_win == RR_W'(i));
    end
  end

  always_comb begin
    bus.btb_wen    = 1'b0;
    bus.btb_valid  = 1'b0;
    bus.btb_pc     = '0;
    bus.btb_target = '0;
    if (w_idle_open && w_any) begin
      bus.btb_wen    = 1'b1;
      bus.btb_valid  = 1'b1;
      bus.btb_pc     = r_pc[w_win][r_rptr[w_win]];
      bus.btb_target = r_tgt[w_win][r_rptr[w_win]];
    end else if (r_state == SWEEP) begin
      bus.btb_wen = 1'b1;
      bus.btb_pc  = 32'({r_idx, 2'b00});
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.flush_busy = (r_state != IDLE);
  assign bus.flush_done = (r_state == DONE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_idx   <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_cnt[i]  <= '0;
        r_rptr[i] <= '0;
        r_wptr[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.flush_req) begin
            // Queued updates predate the flush and are dropped unwritten.
            r_state <= SWEEP;
            r_idx   <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
              r_cnt[i]  <= '0;
              r_rptr[i] <= '0;
              r_wptr[i] <= '0;
            end
          end else begin
            if (w_pop != '0) begin
              r_rr <= (w_win == RR_LAST) ? '0 : w_win + RR_W'(1);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
              if (w_pop[i])  r_rptr[i] <= ptr_inc(r_rptr[i]);
              if (w_push[i]) r_wptr[i] <= ptr_inc(r_wptr[i]);
              r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
            end
          end
        end
        SWEEP: begin
          if (bus.ihit) begin
            r_idx <= r_idx + IDX_SIZE'(1);
            if (r_idx == IDX_LAST) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_push[i]) begin
        r_pc[i][r_wptr[i]]  <= bus.req_pc[32*i +: 32];
        r_tgt[i][r_wptr[i]] <= bus.req_target[32*i +: 32];
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed vector table, hand-written flush/reset
// sequences and random traffic against a queue-based reference model.
module tb_btb_update_ctrl;
  localparam int NREQ  = 2;
  localparam int DEPTH = 2;
  localparam int IDXW  = 8;
  localparam int NIDX  = 1 << IDXW;
  localparam int NVEC  = 22;

  localparam logic [31:0] A0P = 32'h0000_1000, A0T = 32'h0000_2000;
  localparam logic [31:0] A1P = 32'h0000_1004, A1T = 32'h0000_2004;
  localparam logic [31:0] B0P = 32'h0000_3000, B0T = 32'h0000_4000;
  localparam logic [31:0] B1P = 32'h0000_3004, B1T = 32'h0000_4004;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.NREQ(NREQ)) bus ();

  btb_update_ctrl #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .IDX_SIZE(IDXW)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tg;
  } ent_t;

  typedef struct {
    logic        rst_n;
    logic        ihit;
    logic [1:0]  valid;
    logic [31:0] pc0, tg0, pc1, tg1;
    logic        e_wen;
    logic        e_valid;
    logic [31:0] e_pc, e_tg;
    logic [1:0]  e_ready;
  } vec_t;

  vec_t tbl [NVEC];

  // Reference model: one queue per requester, rr pointer, mode 0/1/2 = idle/sweep/done.
  ent_t mq0[$];
  ent_t mq1[$];
  int   m_mode, m_rr, m_idx, m_win;

  logic        e_wen, e_valid, e_busy, e_done;
  logic [31:0] e_pc, e_tg;
  logic [1:0]  e_ready;

  logic        s_wen, s_valid, s_busy, s_done;
  logic [31:0] s_pc, s_tg;
  logic [1:0]  s_ready;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic ih, input logic [1:0] v,
                              input logic [31:0] p0, input logic [31:0] t0,
                              input logic [31:0] p1, input logic [31:0] t1,
                              input logic ew, input logic ev, input logic [31:0] ep,
                              input logic [31:0] et, input logic [1:0] er);
    vec_t x;
    x.rst_n = r;  x.ihit = ih; x.valid = v;
    x.pc0 = p0;   x.tg0 = t0;  x.pc1 = p1; x.tg1 = t1;
    x.e_wen = ew; x.e_valid = ev; x.e_pc = ep; x.e_tg = et; x.e_ready = er;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int j);
    return (j == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic ent_t qhead(input int j);
    return (j == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_mode = 0;
    m_rr   = 0;
    m_idx  = 0;
  endtask

  task automatic model_expect();
    ent_t h;
    e_wen = 1'b0; e_valid = 1'b0; e_pc = '0; e_tg = '0; e_ready = '0;
    e_busy = (m_mode != 0);
    e_done = (m_mode == 2);
    m_win  = -1;
    if (m_mode == 0 && !bus.flush_req) begin
      e_ready[0] = rst_n && (mq0.size() < DEPTH);
      e_ready[1] = rst_n && (mq1.size() < DEPTH);
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (m_win < 0 && qsize(j) > 0) m_win = j;
      end
      if (m_win >= 0) begin
        h = qhead(m_win);
        e_wen = 1'b1; e_valid = 1'b1; e_pc = h.pc; e_tg = h.tg;
      end
    end else if (m_mode == 1) begin
      e_wen = 1'b1;
      e_pc  = 32'(m_idx) << 2;
    end
  endtask

  task automatic model_update();
    case (m_mode)
      0: begin
        if (bus.flush_req) begin
          mq0.delete();
          mq1.delete();
          m_idx  = 0;
          m_mode = 1;
        end else begin
          if (m_win >= 0 && bus.ihit) begin
            if (m_win == 0) void'(mq0.pop_front());
            else            void'(mq1.pop_front());
            m_rr = (m_win + 1) % NREQ;
          end
          if (bus.req_valid[0] && e_ready[0]) mq0.push_back({bus.req_pc[31:0],  bus.req_target[31:0]});
          if (bus.req_valid[1] && e_ready[1]) mq1.push_back({bus.req_pc[63:32], bus.req_target[63:32]});
        end
      end
      1: if (bus.ihit) begin
        if (m_idx == NIDX - 1) m_mode = 2;
        else                   m_idx++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic set_in(input logic r, input logic ih, input logic fl, input logic [1:0] v,
                        input logic [31:0] p0, input logic [31:0] t0,
                        input logic [31:0] p1, input logic [31:0] t1);
    rst_n          = r;
    bus.ihit       = ih;
    bus.flush_req  = fl;
    bus.req_valid  = v;
    bus.req_pc     = {p1, p0};
    bus.req_target = {t1, t0};
  endtask

  // Called with inputs just driven after a falling edge; samples, checks, then clocks.
  task automatic do_cycle();
    #1;
    if (!rst_n) model_reset();
    model_expect();
    s_wen = bus.btb_wen;       s_valid = bus.btb_valid;
    s_pc  = bus.btb_pc;        s_tg    = bus.btb_target;
    s_ready = bus.req_ready;   s_busy  = bus.flush_busy;
    s_done  = bus.flush_done;
    chk("model.wen",   64'(s_wen),   64'(e_wen));
    chk("model.valid", 64'(s_valid), 64'(e_valid));
    chk("model.pc",    64'(s_pc),    64'(e_pc));
    chk("model.tgt",   64'(s_tg),    64'(e_tg));
    chk("model.ready", 64'(s_ready), 64'(e_ready));
    chk("model.busy",  64'(s_busy),  64'(e_busy));
    chk("model.done",  64'(s_done),  64'(e_done));
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  initial begin
    int done_cnt;
    model_reset();

    tbl[0]  = mk(1, 1, 2'b01, 32'h104, 32'hF0, 0, 0,     0, 0, 0,      0,      2'b11);
    tbl[1]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, 32'h104, 32'hF0, 2'b11);
    tbl[2]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                0, 0, 0,      0,      2'b11);
    tbl[3]  = mk(0, 0, 2'b00, 0, 0, 0, 0,                0, 0, 0,      0,      2'b00);
    tbl[4]  = mk(1, 0, 2'b11, A0P, A0T, B0P, B0T,        0, 0, 0,      0,      2'b11);
    tbl[5]  = mk(1, 0, 2'b11, A1P, A1T, B1P, B1T,        1, 1, A0P,    A0T,    2'b11);
    tbl[6]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, A0P,    A0T,    2'b00);
    tbl[7]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, B0P,    B0T,    2'b01);
    tbl[8]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, A1P,    A1T,    2'b11);
    tbl[9]  = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, B1P,    B1T,    2'b11);
    tbl[10] = mk(1, 1, 2'b00, 0, 0, 0, 0,                0, 0, 0,      0,      2'b11);
    tbl[11] = mk(1, 0, 2'b01, A0P, A0T, 0, 0,            0, 0, 0,      0,      2'b11);
    tbl[12] = mk(1, 0, 2'b00, 0, 0, 0, 0,                1, 1, A0P,    A0T,    2'b11);
    tbl[13] = mk(1, 0, 2'b00, 0, 0, 0, 0,                1, 1, A0P,    A0T,    2'b11);
    tbl[14] = mk(1, 0, 2'b00, 0, 0, 0, 0,                1, 1, A0P,    A0T,    2'b11);
    tbl[15] = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, A0P,    A0T,    2'b11);
    tbl[16] = mk(1, 1, 2'b00, 0, 0, 0, 0,                0, 0, 0,      0,      2'b11);
    tbl[17] = mk(1, 0, 2'b01, A0P, A0T, 0, 0,            0, 0, 0,      0,      2'b11);
    tbl[18] = mk(1, 0, 2'b01, A1P, A1T, 0, 0,            1, 1, A0P,    A0T,    2'b11);
    tbl[19] = mk(1, 1, 2'b01, 32'h1008, 32'h2008, 0, 0,  1, 1, A0P,    A0T,    2'b10);
    tbl[20] = mk(1, 1, 2'b00, 0, 0, 0, 0,                1, 1, A1P,    A1T,    2'b11);
    tbl[21] = mk(1, 1, 2'b00, 0, 0, 0, 0,                0, 0, 0,      0,      2'b11);

    // Reset state.
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      chk("rst.wen",   64'(s_wen),   64'(0));
      chk("rst.ready", 64'(s_ready), 64'(0));
      chk("rst.busy",  64'(s_busy),  64'(0));
      chk("rst.pc",    64'(s_pc),    64'(0));
    end

    // Directed vectors: single update, contention, ihit stall, full FIFO with pop.
    for (int r = 0; r < NVEC; r++) begin
      set_in(tbl[r].rst_n, tbl[r].ihit, 1'b0, tbl[r].valid,
             tbl[r].pc0, tbl[r].tg0, tbl[r].pc1, tbl[r].tg1);
      do_cycle();
      chk($sformatf("vec%0d.wen", r),   64'(s_wen),   64'(tbl[r].e_wen));
      chk($sformatf("vec%0d.valid", r), 64'(s_valid), 64'(tbl[r].e_valid));
      chk($sformatf("vec%0d.pc", r),    64'(s_pc),    64'(tbl[r].e_pc));
      chk($sformatf("vec%0d.tgt", r),   64'(s_tg),    64'(tbl[r].e_tg));
      chk($sformatf("vec%0d.ready", r), 64'(s_ready), 64'(tbl[r].e_ready));
    end

    // Flush with three stale entries queued.
    set_in(1, 0, 0, 2'b11, A0P, A0T, B0P, B0T); do_cycle();
    set_in(1, 0, 0, 2'b01, A1P, A1T, 0, 0);     do_cycle();
    set_in(1, 1, 1, 2'b11, 32'h5000, 32'h6000, 32'h7000, 32'h8000); do_cycle();
    chk("flush.req_wen",   64'(s_wen),   64'(0));
    chk("flush.req_ready", 64'(s_ready), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < NIDX; i++) begin
      set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
      chk("sweep.pc",    64'(s_pc),    64'(32'(i) << 2));
      chk("sweep.wen",   64'(s_wen),   64'(1));
      chk("sweep.valid", 64'(s_valid), 64'(0));
      chk("sweep.busy",  64'(s_busy),  64'(1));
      if (s_done) done_cnt++;
    end
    set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    chk("flush.done", 64'(s_done), 64'(1));
    chk("flush.done_wen", 64'(s_wen), 64'(0));
    if (s_done) done_cnt++;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
      chk("flush.no_stale_wen", 64'(s_wen), 64'(0));
      chk("flush.idle_busy",    64'(s_busy), 64'(0));
      if (s_done) done_cnt++;
    end
    chk("flush.done_pulses", 64'(done_cnt), 64'(1));

    // Reset in the middle of a sweep at index 0x40.
    set_in(1, 1, 1, 2'b00, 0, 0, 0, 0); do_cycle();
    for (int i = 0; i < 64; i++) begin
      set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    end
    set_in(1, 0, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    chk("rsw.idx_pc", 64'(s_pc), 64'(32'h100));
    set_in(0, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    chk("rsw.wen",   64'(s_wen),   64'(0));
    chk("rsw.pc",    64'(s_pc),    64'(0));
    chk("rsw.busy",  64'(s_busy),  64'(0));
    chk("rsw.ready", 64'(s_ready), 64'(0));
    set_in(1, 1, 0, 2'b01, A0P, A0T, 0, 0); do_cycle();
    chk("rsw.push_ready", 64'(s_ready), 64'(2'b11));
    set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    chk("rsw.commit_wen", 64'(s_wen), 64'(1));
    chk("rsw.commit_pc",  64'(s_pc),  64'(A0P));
    set_in(1, 1, 0, 2'b00, 0, 0, 0, 0); do_cycle();
    chk("rsw.after_wen", 64'(s_wen), 64'(0));

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic r, ih, fl;
      r  = ($urandom_range(0, 499) != 0);
      ih = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 299) == 0);
      set_in(r, ih, fl, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
